// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: sequencer between the UART receiver/transmitter and the ALU.
// Collects operand A, operand B and opcode bytes, lets the ALU settle for one
// cycle, latches the result and launches a single UART transmission of it.
// An inter-byte timeout abandons stalled frames; bytes arriving while a
// result is in flight are dropped and flagged as overruns.
module uart_alu_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int NB_TMO      = 20
) (
    input  logic               i_Clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_active,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t              state_reg;
    logic [NB_TMO-1:0]   tmo_cnt_reg;
    logic                tmo_hit;

    // Expiry is detected on the last allowed count; a zero limit removes the
    // timeout entirely so a frame may stall forever.
    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYC - 1);
            assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    // Frame sequencer: state, operand/result registers, pulses and timeout counter.
    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            state_reg   <= WAIT_A;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
            o_overrun   <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;

            case (state_reg)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_a     <= i_rx_data;
                        tmo_cnt_reg <= '0;
                        o_busy      <= 1'b1;
                        state_reg   <= WAIT_B;
                    end
                end

                WAIT_B: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (i_rx_done) begin
                        o_alu_b     <= i_rx_data;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_OP;
                    end else if (tmo_hit) begin
                        tmo_cnt_reg <= '0;
                        o_timeout   <= 1'b1;
                        o_busy      <= 1'b0;
                        state_reg   <= WAIT_A;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + NB_TMO'(1);
                    end
                end

                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_op    <= i_rx_data[NB_OP-1:0];
                        tmo_cnt_reg <= '0;
                        state_reg   <= EXEC;
                    end else if (tmo_hit) begin
                        tmo_cnt_reg <= '0;
                        o_timeout   <= 1'b1;
                        o_busy      <= 1'b0;
                        state_reg   <= WAIT_A;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + NB_TMO'(1);
                    end
                end

                EXEC: begin
                    // The ALU has had one full cycle on the new opcode.
                    o_tx_data <= i_alu_result;
                    o_overrun <= i_rx_done;
                    state_reg <= SEND;
                end

                SEND: begin
                    o_overrun <= i_rx_done;
                    if (!i_tx_active) begin
                        o_tx_start <= 1'b1;
                        state_reg  <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    o_overrun <= i_rx_done;
                    if (i_tx_done) begin
                        o_busy    <= 1'b0;
                        state_reg <= WAIT_A;
                    end
                end

                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: ALU stand-in, simple UART transmitter model,
// randomized frames checked against an arithmetic reference of the ALU and
// the frame timing rules (latency, busy, timeout, overrun, reset).
module tb_uart_alu_ctrl;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 100;

    logic               i_Clock;
    logic               i_reset;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_tx_active;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge = 0;
    int done_cyc  = -1;
    int n_start = 0;
    int n_tmo   = 0;
    int n_ovr   = 0;
    logic uart_active;
    logic hold_active;

    // Reference ALU: opcode meanings from the TP2 ALU.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);
    assign i_tx_active  = uart_active | hold_active;

    uart_alu_ctrl #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(TMO), .NB_TMO(20)
    ) dut (
        .i_Clock(i_Clock), .i_reset(i_reset),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
        .i_alu_result(i_alu_result),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle.
    always @(negedge i_Clock) begin
        if (o_tx_start) n_start <= n_start + 1;
        if (o_timeout)  n_tmo   <= n_tmo + 1;
        if (o_overrun)  n_ovr   <= n_ovr + 1;
    end

    // UART transmitter model: busy for 8 cycles after a start, then done pulse.
    initial begin
        uart_active = 1'b0;
        i_tx_done   = 1'b0;
        forever begin
            @(posedge i_Clock); #1;
            if (o_tx_start) begin
                uart_active = 1'b1;
                repeat (8) begin @(posedge i_Clock); #1; end
                uart_active = 1'b0;
                i_tx_done   = 1'b1;
                @(posedge i_Clock); #1;
                done_cyc  = cyc;
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clock); #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_Clock); #2;
        last_edge = cyc;
        i_rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] opb, input int gap);
        send_byte(a);
        repeat (gap) step();
        send_byte(b);
        repeat (gap) step();
        send_byte(opb);
    endtask

    // Called right after the opcode byte was sampled.
    // mode 0: UART idle, mode 1: UART held busy 50 cycles, mode 2: overrun byte in WAIT_TX.
    task automatic finish_frame(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] opb, input int mode);
        logic [7:0] exp;
        int k;
        int n0;
        int o0;
        exp = alu_ref(a, b, opb[5:0]);
        n0  = n_start;
        check_val("alu_a", o_alu_a, a);
        check_val("alu_b", o_alu_b, b);
        check_val("alu_op", o_alu_op, opb & 8'h3f);
        check_val("busy_frame", o_busy, 1);
        if (mode == 1) begin
            step(); step();
            for (int i = 0; i < 50; i++) begin
                check_val("hold_start", o_tx_start, 0);
                check_val("hold_data", o_tx_data, exp);
                step();
            end
            hold_active = 1'b0;
        end
        k = 0;
        while (!o_tx_start && k < 200) begin step(); k++; end
        check_val("start_lat", k, (mode == 1) ? 1 : 2);
        check_val("tx_data", o_tx_data, exp);
        if (mode == 2) begin
            o0 = n_ovr;
            send_byte(8'h55);
            step();
            check_val("ovr_pulse", n_ovr - o0, 1);
            check_val("ovr_alu_a", o_alu_a, a);
            check_val("ovr_busy", o_busy, 1);
        end
        k = 0;
        while (o_busy && k < 100) begin step(); k++; end
        check_val("busy_to", o_busy, 0);
        check_val("busy_drop", cyc, done_cyc);
        check_val("one_start", n_start - n0, 1);
        $display("frame a=%02h b=%02h op=%02h res=%02h tx=%02h mode=%0d", a, b, opb, exp, o_tx_data, mode);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input int gap, input int mode);
        if (mode == 1) hold_active = 1'b1;
        send_frame(a, b, opb, gap);
        finish_frame(a, b, opb, mode);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] prev_b;
        int e;
        int k;
        int t0;
        ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25;
        ops[4] = 8'h26; ops[5] = 8'h27; ops[6] = 8'h03; ops[7] = 8'h02;

        hold_active = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = '0;
        i_reset     = 1'b1;
        repeat (3) step();
        i_reset = 1'b0;
        check_val("rst_a", o_alu_a, 0);
        check_val("rst_b", o_alu_b, 0);
        check_val("rst_op", o_alu_op, 0);
        check_val("rst_txd", o_tx_data, 0);
        check_val("rst_start", o_tx_start, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_tmo", o_timeout, 0);
        check_val("rst_ovr", o_overrun, 0);
        step();

        // Directed frames: ADD, back-to-back SUB and OR.
        run_frame(8'd22, 8'd18, 8'h20, 0, 0);
        run_frame(8'd22, 8'd18, 8'h22, 0, 0);
        run_frame(8'h0F, 8'hF0, 8'h25, 0, 0);

        // UART busy when SEND is entered.
        run_frame(8'h31, 8'h07, 8'h26, 1, 1);

        // Timeout after a single byte.
        prev_b = o_alu_b;
        t0 = n_tmo;
        send_byte(8'd5);
        e = last_edge;
        k = 0;
        while (!o_timeout && k < 300) begin step(); k++; end
        check_val("tmo_at", cyc - e, TMO);
        check_val("tmo_busy", o_busy, 0);
        check_val("tmo_a", o_alu_a, 5);
        check_val("tmo_b", o_alu_b, prev_b);
        step();
        check_val("tmo_width", o_timeout, 0);
        check_val("tmo_count", n_tmo - t0, 1);
        run_frame(8'd3, 8'd4, 8'h20, 0, 0);

        // Second byte lands exactly on the expiry cycle: accepted, no timeout.
        t0 = n_tmo;
        send_byte(8'd9);
        e = last_edge;
        repeat (TMO - 1) step();
        send_byte(8'h0A);
        step();
        check_val("edge_no_tmo", n_tmo - t0, 0);
        check_val("edge_busy", o_busy, 1);
        check_val("edge_b", o_alu_b, 8'h0A);
        send_byte(8'h20);
        finish_frame(8'd9, 8'h0A, 8'h20, 0);

        // Overrun during WAIT_TX, then a clean frame.
        run_frame(8'h12, 8'h34, 8'h20, 1, 2);
        run_frame(8'h40, 8'h02, 8'h02, 0, 0);

        // Reset in WAIT_OP after two bytes.
        send_byte(8'h11);
        send_byte(8'h22);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check_val("mid_rst_a", o_alu_a, 0);
        check_val("mid_rst_b", o_alu_b, 0);
        check_val("mid_rst_busy", o_busy, 0);
        step();
        run_frame(8'd1, 8'd2, 8'h20, 0, 0);

        // Randomized frames with random gaps and junk in the opcode top bits.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb, rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = ops[$urandom_range(0, 7)] | 8'($urandom_range(0, 3) << 6);
            run_frame(ra, rb, rop, $urandom_range(0, 4), 0);
            repeat ($urandom_range(0, 3)) step();
        end

        check_val("total_tmo", n_tmo, 1);
        check_val("total_ovr", n_ovr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART and the ALU in the TP2 design.
- Collects three received bytes in order: operand A, operand B, opcode. Presents them to the ALU, latches the result, and starts one UART transmission of that result.
- Includes an inter-byte timeout so a stalled frame does not wedge the system. Includes overrun flagging for bytes that arrive while a result is in flight.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and ALU result.
- NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYC, 1_000_000, clock cycles allowed between bytes of one frame; 0 disables the timeout.
- NB_TMO, 20, timeout counter width; must satisfy 2^NB_TMO > TIMEOUT_CYC.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous active-high reset
- i_rx_done  in  1  one-cycle pulse: a byte is valid on i_rx_data
- i_rx_data  in  NB_DATA  received byte
- i_tx_active  in  1  UART transmitter busy
- i_tx_done  in  1  one-cycle pulse: transmission finished
- i_alu_result  in  NB_DATA  combinational ALU output
- o_alu_a  out  NB_DATA  operand A to ALU
- o_alu_b  out  NB_DATA  operand B to ALU
- o_alu_op  out  NB_OP  opcode to ALU
- o_tx_start  out  1  one-cycle pulse starting transmission
- o_tx_data  out  NB_DATA  byte to transmit (latched ALU result)
- o_busy  out  1  high in any state other than WAIT_A
- o_timeout  out  1  one-cycle pulse: frame abandoned on timeout
- o_overrun  out  1  one-cycle pulse: byte received and dropped

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - state to WAIT_A
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data to 0
  - o_tx_start, o_busy, o_timeout, o_overrun to 0
  - timeout counter to 0
  - Reset overrides every other input, including mid-frame and mid-WAIT_TX. A UART transmission already started is not aborted by this block.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_alu_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
- EXEC: single settle cycle for the ALU. o_tx_data <= i_alu_result, go to SEND.
- SEND:
  - if i_tx_active=0: o_tx_start=1 for exactly this one cycle, go to WAIT_TX.
  - otherwise stay in SEND with o_tx_start=0; o_tx_data is held.
- WAIT_TX: on i_tx_done, go to WAIT_A. i_tx_done in any other state is ignored.
- Latency: opcode i_rx_done sampled at edge N gives EXEC during cycle N+1 and o_tx_start high during cycle N+2 (when the UART is idle).
- Operand and opcode registers hold their values until overwritten by the next frame.
- Timeout (TIMEOUT_CYC>0):
  - counter cleared on entry to WAIT_B and on every i_rx_done; increments each cycle in WAIT_B/WAIT_OP.
  - when the counter reaches TIMEOUT_CYC-1 without i_rx_done: go to WAIT_A, o_timeout=1 for one cycle, o_alu_* unchanged.
  - i_rx_done in the same cycle as expiry wins: the byte is accepted and there is no timeout.
  - no timeout in WAIT_A, EXEC, SEND, WAIT_TX.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte, sets o_overrun=1 for one cycle, and leaves the state unchanged.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset, then bytes 22, 18, 0x20 (ADD) with an ALU model -> o_alu_a=22, o_alu_b=18, o_alu_op=0x20; o_tx_start pulses once 2 cycles after the third rx_done, o_tx_data=40; o_busy drops 1 cycle after i_tx_done.
- Back-to-back frames (22, 18, 0x22 SUB) then (0x0F, 0xF0, 0x25 OR) -> results 4 then 0xFF, exactly one o_tx_start per frame.
- i_tx_active held high for 50 cycles when SEND is entered -> o_tx_start stays 0, then pulses in the first cycle i_tx_active=0; o_tx_data is stable throughout.
- TIMEOUT_CYC=100: send byte 5, then silence -> o_timeout pulses 100 cycles after the rx_done that took the FSM to WAIT_B, state is WAIT_A; a following full frame 3, 4, 0x20 yields 7. Repeat with the second byte arriving exactly at the expiry cycle -> no timeout.
- Byte 0x55 received during WAIT_TX -> o_overrun pulses once, result transmission unaffected; the next frame starts cleanly with operand A.
- Reset asserted in WAIT_OP after 2 bytes -> all outputs 0, state WAIT_A; a new frame 1, 2, 0x20 produces 3.
